instr_encoder: RTL

- Inverse of the immediate decoder. Takes decoded instruction fields plus a 32-bit signed or absolute immediate, checks that the immediate is encodable for the selected format, scatters it into RV32I bit positions and emits the 32-bit instruction word.
- Used by the self-test/boot stream generator to build IMEM images in hardware.
- Two-stage valid/ready pipeline. Output carries a running word address for the IMEM write port.

---
 rtl/instr_encoder_if.sv | 42 ++++
 rtl/instr_encoder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Format selector shared with the decoder side, plus the encoder's bus bundle.
// The encoder drives the slave modport; the stream generator drives the master.
package control_pkg;
  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_sel_e;
endpackage

interface instr_encoder_if #(parameter int ADDR_W = 32);
  import control_pkg::*;
  logic              in_valid;
  logic              in_ready;
  imm_sel_e          imm_sel;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic [1:0]        out_err;
  logic [15:0]       err_cnt;
  logic              err_sticky;

  modport master (
    output in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_cnt, err_sticky
  );
  modport slave (
    input  in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_cnt, err_sticky
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I immediate encoder. Stage 1 checks and packs the
// immediate, stage 2 holds the output word with its running IMEM address.
// Optional feature macro INSTR_ENCODER_ROUNDTRIP_EN adds rt_mismatch, a
// decode-back check of the stage-2 word against the original immediate.
module instr_encoder
  import control_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              STRICT    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  instr_encoder_if.slave  bus
`ifdef INSTR_ENCODER_ROUNDTRIP_EN
  ,
  output logic            rt_mismatch
`endif
);

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  err;   // bit0 range, bit1 misaligned
`ifdef INSTR_ENCODER_ROUNDTRIP_EN
    imm_sel_e    sel;
    logic [31:0] imm;
`endif
  } stage_t;

  stage_t            enc, s1, s2;
  logic              s1_valid, s2_valid;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       err_cnt;
  logic              err_sticky;
  logic              s1_advance, in_ready, in_fire, out_fire, s1_fail, s1_drop;

  assign s1_advance = !s2_valid || bus.out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign in_fire    = bus.in_valid && in_ready;
  assign out_fire   = s2_valid && bus.out_ready;
  assign s1_fail    = (s1.err != 2'b00);
  // In strict mode a failing word is consumed here and never occupies stage 2
  assign s1_drop    = (STRICT != 0) && s1_fail;

  // Check and scatter the immediate for the selected format
  always_comb begin
    enc       = '0;
    enc.instr = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
    enc.err   = 2'b00;
`ifdef INSTR_ENCODER_ROUNDTRIP_EN
    enc.sel   = bus.imm_sel;
    enc.imm   = bus.imm;
`endif
    case (bus.imm_sel)
      IMM_I: begin
        enc.instr  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        enc.err[0] = !((bus.imm[31:11] == '0) || (bus.imm[31:11] == '1));
      end
      IMM_S: begin
        enc.instr  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
        enc.err[0] = !((bus.imm[31:11] == '0) || (bus.imm[31:11] == '1));
      end
      IMM_B: begin
        enc.instr  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                      bus.imm[4:1], bus.imm[11], bus.opcode};
        enc.err[0] = !((bus.imm[31:12] == '0) || (bus.imm[31:12] == '1));
        enc.err[1] = bus.imm[0];
      end
      IMM_U: begin
        enc.instr  = {bus.imm[31:12], bus.rd, bus.opcode};
        enc.err[1] = (bus.imm[11:0] != 12'd0);
      end
      IMM_J: begin
        enc.instr  = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                      bus.rd, bus.opcode};
        enc.err[0] = !((bus.imm[31:20] == '0) || (bus.imm[31:20] == '1));
        enc.err[1] = bus.imm[0];
      end
      IMM_NONE: ;
      // Unknown selector: keep the R-style packing, flag as range error
      default: enc.err = 2'b01;
    endcase
  end

  // Two-stage pipe, address counter and error bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1         <= '0;
      s2         <= '0;
      addr       <= BASE_ADDR;
      err_cnt    <= 16'd0;
      err_sticky <= 1'b0;
    end else if (clear) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      addr       <= BASE_ADDR;
      err_cnt    <= 16'd0;
      err_sticky <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= bus.in_valid;
      if (in_fire)  s1       <= enc;
      if (s1_advance) begin
        s2_valid <= s1_valid && !s1_drop;
        if (s1_valid && !s1_drop) s2 <= s1;
      end
      if (s1_valid && s1_advance && s1_fail) begin
        err_sticky <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
      if (out_fire) addr <= addr + ADDR_W'(4);
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = s2_valid;
  assign bus.out_instr  = s2.instr;
  assign bus.out_err    = s2.err;
  assign bus.out_addr   = addr;
  assign bus.err_cnt    = err_cnt;
  assign bus.err_sticky = err_sticky;

`ifdef INSTR_ENCODER_ROUNDTRIP_EN
  logic [31:0] dec_imm;
  logic [31:0] w;
  assign w = s2.instr;

  // Decode the emitted word back to an immediate, as immgen would
  always_comb begin
    dec_imm = s2.imm;
    case (s2.sel)
      IMM_I:   dec_imm = {{20{w[31]}}, w[31:20]};
      IMM_S:   dec_imm = {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   dec_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   dec_imm = {w[31:12], 12'd0};
      IMM_J:   dec_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: dec_imm = s2.imm;
    endcase
  end

  assign rt_mismatch = s2_valid && (s2.err == 2'b00) && (s2.sel != IMM_NONE) &&
                       (dec_imm != s2.imm);
`endif

endmodule
